// File: rtl/osd_dem_uart_pkg.sv
// Shared definitions for the UART device-emulation character path.
//   ASCII_*      : characters the arbiter emits or recognises
//   arb_state_e  : encoding of the arbiter FSM states
package osd_dem_uart_pkg;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PREFIX_ID  = 2'd1,
    ST_PREFIX_SEP = 2'd2,
    ST_STREAM     = 2'd3
  } arb_state_e;

endpackage

// File: rtl/osd_dem_uart_arb_if.sv
// Character-stream bundle between N_PORTS UART front-ends and the merged
// output towards the packetizer.
//   req_valid/req_char/req_ready : per-port input streams
//   out_valid/out_char/out_ready : merged output stream
//   owner/owner_valid            : current grant holder
// Modports: master = requesters plus downstream sink, slave = the arbiter.
interface osd_dem_uart_arb_if #(
  parameter int N_PORTS = 4
);
  localparam int OW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS-1:0]       req_valid;
  logic [N_PORTS-1:0][7:0]  req_char;
  logic [N_PORTS-1:0]       req_ready;
  logic                     out_valid;
  logic [7:0]               out_char;
  logic                     out_ready;
  logic [OW-1:0]            owner;
  logic                     owner_valid;

  modport master (
    output req_valid, req_char, out_ready,
    input  req_ready, out_valid, out_char, owner, owner_valid
  );

  modport slave (
    input  req_valid, req_char, out_ready,
    output req_ready, out_valid, out_char, owner, owner_valid
  );

endinterface

// File: rtl/osd_rr_arbiter.sv
// Combinational round-robin picker. Searches req starting at last+1 with
// wrap-around and returns the first set bit.
//   req       : request vector
//   last      : index of the previous winner
//   grant     : one-hot winner (all zero when no request)
//   grant_idx : encoded winner (0 when no request)
module osd_rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  logic         found;
  logic [W-1:0] cand;

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = W'((int'(last) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/osd_dem_uart_arb.sv
// Line-atomic round-robin merger of up to ten UART transmit streams.
// A winner keeps the output until it sends LF or stays silent for TIMEOUT
// streaming cycles; each grant is optionally tagged with "<id>:".
//   clk, rst : clock, synchronous active-high reset
//   bus      : osd_dem_uart_arb_if slave (request streams, merged output,
//              owner / owner_valid)
module osd_dem_uart_arb
  import osd_dem_uart_pkg::*;
#(
  parameter int N_PORTS   = 4,
  parameter int TIMEOUT   = 255,
  parameter bit PREFIX_EN = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  osd_dem_uart_arb_if.slave   bus
);

  localparam int OW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // Plain constants mirroring the shared enum encoding.
  localparam logic [1:0] S_IDLE       = ST_IDLE;
  localparam logic [1:0] S_PREFIX_ID  = ST_PREFIX_ID;
  localparam logic [1:0] S_PREFIX_SEP = ST_PREFIX_SEP;
  localparam logic [1:0] S_STREAM     = ST_STREAM;

  logic [1:0]         state, state_nxt;
  logic [OW-1:0]      owner_q, last_q;
  logic [TW-1:0]      tmo_cnt;
  logic [N_PORTS-1:0] grant;
  logic [OW-1:0]      grant_idx;
  logic               any_req, xfer, tmo_hit;

  osd_rr_arbiter #(.N(N_PORTS), .W(OW)) u_rr (
    .req       (bus.req_valid),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign any_req = |grant;
  assign xfer    = bus.out_valid & bus.out_ready;
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT));

  assign bus.owner       = owner_q;
  assign bus.owner_valid = (state != S_IDLE) && !rst;

  // Output mux. The streaming path is purely combinational so a granted
  // port sees zero added latency. During reset nothing is offered or taken,
  // which also abandons any half-sent prefix.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_char  = '0;
    bus.req_ready = '0;
    unique case (state)
      S_PREFIX_ID: begin
        bus.out_valid = 1'b1;
        bus.out_char  = ASCII_ZERO + 8'(owner_q);
      end
      S_PREFIX_SEP: begin
        bus.out_valid = 1'b1;
        bus.out_char  = ASCII_COLON;
      end
      S_STREAM: begin
        bus.out_valid          = bus.req_valid[owner_q];
        bus.out_char           = bus.req_char[owner_q];
        bus.req_ready[owner_q] = bus.out_ready;
      end
      default: ;
    endcase
    if (rst) begin
      bus.out_valid = 1'b0;
      bus.req_ready = '0;
    end
  end

  // A transfer in the same cycle as the timeout wins: only LF releases then.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:       if (any_req) state_nxt = PREFIX_EN ? S_PREFIX_ID : S_STREAM;
      S_PREFIX_ID:  if (bus.out_ready) state_nxt = S_PREFIX_SEP;
      S_PREFIX_SEP: if (bus.out_ready) state_nxt = S_STREAM;
      S_STREAM: begin
        if (xfer) begin
          if (bus.out_char == ASCII_LF) state_nxt = S_IDLE;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
        end
      end
      default:      state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      owner_q <= '0;
      last_q  <= OW'(N_PORTS - 1);
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && any_req) begin
        owner_q <= grant_idx;
        last_q  <= grant_idx;
      end
      // Held at zero outside STREAM, so it starts clean on every entry.
      if (state != S_STREAM || xfer) tmo_cnt <= '0;
      else                           tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_osd_dem_uart_arb.sv
// Scoreboard bench for osd_dem_uart_arb (N_PORTS=4, TIMEOUT=4, prefixes on).
// Stimulus loads per-port character queues; a line-level model turns those
// into the expected merged stream, which a monitor compares on every transfer.
module tb_osd_dem_uart_arb;
  import osd_dem_uart_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 4;

  typedef struct { logic [7:0] c; int gap; } item_t;
  typedef struct { logic [7:0] c; int port; bit prefix; } exp_t;

  logic clk, rst;
  osd_dem_uart_arb_if #(.N_PORTS(N)) bus ();

  osd_dem_uart_arb #(.N_PORTS(N), .TIMEOUT(TMO), .PREFIX_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  item_t port_q [N][$];
  exp_t  exp_q [$];
  exp_t  mon_e;
  int    gap_cnt [N];
  bit    acc [N];
  int    m_last;
  bit    sb_on, rnd_ready;
  int    low_run;
  int    errors, checks;
  int    cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic add_char(input int p, input logic [7:0] ch, input int g);
    port_q[p].push_back('{c: ch, gap: g});
  endtask

  task automatic add_line(input int p, input string s);
    for (int i = 0; i < s.len(); i++) add_char(p, s[i], 0);
  endtask

  function automatic int pending();
    int n = 0;
    for (int p = 0; p < N; p++) n += port_q[p].size();
    return n;
  endfunction

  // Line-level reference: ports take turns from the one after the previous
  // winner; each grant is "<id>:" followed by that port's chars up to and
  // including LF, or up to the point the port runs dry (timeout release).
  function automatic void run_model();
    logic [7:0] m_q [N][$];
    logic [7:0] ch;
    int w;
    for (int p = 0; p < N; p++)
      foreach (port_q[p][k]) m_q[p].push_back(port_q[p][k].c);
    while (1) begin
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && m_q[(m_last + k) % N].size() > 0) w = (m_last + k) % N;
      if (w < 0) break;
      m_last = w;
      exp_q.push_back('{c: 8'(8'h30 + w), port: w, prefix: 1'b1});
      exp_q.push_back('{c: 8'h3A, port: w, prefix: 1'b1});
      do begin
        ch = m_q[w].pop_front();
        exp_q.push_back('{c: ch, port: w, prefix: 1'b0});
      end while (ch != 8'h0A && m_q[w].size() > 0);
    end
  endfunction

  // Requester and sink driver: pops a char after its handshake, honours the
  // per-char gap, and optionally randomises out_ready (never low >2 cycles).
  initial begin
    bus.req_valid = '0;
    bus.req_char  = '0;
    for (int p = 0; p < N; p++) gap_cnt[p] = 0;
    low_run = 0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < N; p++) acc[p] = bus.req_valid[p] & bus.req_ready[p];
      @(posedge clk);
      #1;
      for (int p = 0; p < N; p++) begin
        if (acc[p] && port_q[p].size() > 0) begin
          void'(port_q[p].pop_front());
          gap_cnt[p] = (port_q[p].size() > 0) ? port_q[p][0].gap : 0;
        end else if (gap_cnt[p] > 0) begin
          gap_cnt[p]--;
        end
        bus.req_valid[p] = (port_q[p].size() > 0) && (gap_cnt[p] == 0);
        bus.req_char[p]  = (port_q[p].size() > 0) ? port_q[p][0].c : 8'h00;
      end
      if (rnd_ready) begin
        if (low_run >= 2 || $urandom_range(0, 3) != 0) begin
          bus.out_ready = 1'b1;
          low_run = 0;
        end else begin
          bus.out_ready = 1'b0;
          low_run++;
        end
      end
    end
  end

  // Monitor: every accepted output char must be the next expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && sb_on && bus.out_valid && bus.out_ready) begin
        check("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("out_char", 32'(bus.out_char), 32'(mon_e.c));
          check("owner", 32'(bus.owner), 32'(mon_e.port));
          check("owner_valid", 32'(bus.owner_valid), 32'd1);
          check("req_ready", 32'(bus.req_ready), mon_e.prefix ? 32'd0 : (32'd1 << mon_e.port));
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || pending() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size() + pending()), 32'd0);
    exp_q.delete();
    for (int p = 0; p < N; p++) port_q[p].delete();
    repeat (3) @(negedge clk);
    check({name, "_idle_after"}, 32'(bus.owner_valid), 32'd0);
  endtask

  initial begin
    int n, t_b, t_rel;
    int nl, len;
    errors = 0; checks = 0; sb_on = 1'b0; rnd_ready = 1'b0;
    rst = 1'b1; bus.out_ready = 1'b0; m_last = N - 1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_owner_valid", 32'(bus.owner_valid), 32'd0);
    check("rst_out_char", 32'(bus.out_char), 32'd0);
    check("rst_owner", 32'(bus.owner), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);

    // Single port 2 sends "A\n".
    step(); bus.out_ready = 1'b1; sb_on = 1'b1;
    add_line(2, "A\n"); run_model(); wait_drain("single", 50);

    // Ports 0 and 1 alternate.
    step();
    add_line(0, "x\n"); add_line(0, "x\n"); add_line(1, "x\n"); add_line(1, "x\n");
    run_model(); wait_drain("alternate", 100);

    // Prefix held while out_ready is low.
    step(); bus.out_ready = 1'b0;
    add_line(0, "x\n"); run_model();
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_char", 32'(bus.out_char), 32'h30);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    step(); bus.out_ready = 1'b1;
    wait_drain("stall", 50);

    // Timeout release: port 1 sends "ab" and goes silent; port 3 waits.
    step();
    add_line(1, "ab"); add_line(3, "z\n"); run_model();
    t_b = -1; t_rel = -1; n = 0;
    while (t_rel < 0 && n < 80) begin
      @(negedge clk); n++;
      if (bus.out_valid && bus.out_ready && bus.out_char == 8'h62) t_b = cyc;
      else if (t_b >= 0 && !bus.owner_valid) t_rel = cyc;
    end
    check("tmo_release_gap", 32'(t_rel - t_b), 32'd6);
    wait_drain("timeout", 80);

    // LF arrives exactly when the idle counter equals TIMEOUT.
    step();
    add_char(0, 8'h71, 0); add_char(0, 8'h0A, TMO); add_line(2, "y\n");
    run_model(); wait_drain("lf_at_tmo", 80);

    // Ordinary char at the timeout boundary keeps the grant.
    step();
    add_char(0, 8'h71, 0); add_char(0, 8'h72, TMO); add_char(0, 8'h0A, 0); add_line(3, "w\n");
    run_model(); wait_drain("char_at_tmo", 80);

    // Reset while in PREFIX_SEP.
    step(); sb_on = 1'b0; bus.out_ready = 1'b0;
    add_line(2, "k\n");
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    check("rst_pid_char", 32'(bus.out_char), 32'h32);
    step(); bus.out_ready = 1'b1;
    @(negedge clk);
    step(); bus.out_ready = 1'b0;
    @(negedge clk);
    check("rst_sep_char", 32'(bus.out_char), 32'h3A);
    step(); rst = 1'b1; bus.out_ready = 1'b1; port_q[2].delete();
    @(negedge clk);
    check("rst_cycle_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_cycle_req_ready", 32'(bus.req_ready), 32'd0);
    step(); rst = 1'b0; bus.out_ready = 1'b0; m_last = N - 1;
    @(negedge clk);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_owner_valid", 32'(bus.owner_valid), 32'd0);
    check("post_rst_owner", 32'(bus.owner), 32'd0);
    step(); sb_on = 1'b1; bus.out_ready = 1'b1;
    add_line(2, "m\n"); add_line(0, "n\n");
    run_model(); wait_drain("post_rst", 80);

    // Random lines on all ports with random backpressure.
    rnd_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      step();
      for (int p = 0; p < N; p++) begin
        nl = $urandom_range(0, 3);
        for (int l = 0; l < nl; l++) begin
          len = $urandom_range(0, 5);
          for (int k = 0; k < len; k++) add_char(p, 8'($urandom_range(32'h20, 32'h7E)), 0);
          add_char(p, 8'h0A, 0);
        end
      end
      run_model();
      wait_drain("random", 600);
    end
    rnd_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/osd_dem_uart_arb.md
# osd_dem_uart_arb

Round-robin, line-atomic arbiter that merges the transmit character streams of up to ten UART device-emulation front-ends into the single character stream feeding the debug interconnect packetizer. A port keeps ownership until it sends a line feed or goes silent for TIMEOUT cycles. Each grant is optionally preceded by an ASCII tag ("<id>:"), so host-side output from several cores stays readable.

## Interface

Parameters:
- N_PORTS, default 4: number of requesting char streams, legal range 1..10.
- TIMEOUT, default 255: consecutive idle STREAM cycles before forced release; 0 disables the timeout.
- PREFIX_EN, default 1: emit a two-char tag before each grant.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  N_PORTS  per-port char valid.
- req_char  in  N_PORTS x 8 (packed [N_PORTS-1:0][7:0])  per-port char.
- req_ready  out  N_PORTS  per-port char accepted.
- out_valid  out  1  merged char valid.
- out_char  out  8  merged char.
- out_ready  in  1  downstream accepts char.
- owner  out  clog2(N_PORTS), min 1  current owner index.
- owner_valid  out  1  high in PREFIX_ID, PREFIX_SEP and STREAM.

## Operation

- FSM states are IDLE, PREFIX_ID, PREFIX_SEP and STREAM. Reset state is IDLE, with owner=0 and last=N_PORTS-1, so port 0 has first priority.
- Outputs after reset: out_valid=0, req_ready=0, owner_valid=0, out_char=0.
- IDLE:
  - out_valid=0 and all req_ready=0.
  - If any req_valid is set, pick the first set bit searching from last+1 with wrap-around.
  - Register the winner in owner and last.
  - Next state is PREFIX_ID if PREFIX_EN, else STREAM.
- PREFIX_ID:
  - out_valid=1, out_char=8'h30+owner.
  - Advances to PREFIX_SEP on out_ready; otherwise the char is held.
- PREFIX_SEP:
  - out_valid=1, out_char=8'h3A (':').
  - Advances to STREAM on out_ready.
- STREAM:
  - out_valid=req_valid[owner], out_char=req_char[owner], req_ready[owner]=out_ready. All other req_ready bits are 0.
  - A transfer is out_valid & out_ready.
  - A transfer of 8'h0A moves the FSM to IDLE.
- Timeout counter:
  - Width is clog2(TIMEOUT+1).
  - Cleared on STREAM entry and on every transfer.
  - Incremented on each STREAM cycle without a transfer.
  - When it equals TIMEOUT, the next state is IDLE.
  - A transfer in the same cycle takes precedence: the counter clears and the FSM stays in STREAM unless the char was LF.
- Ports not granted see req_ready=0. Requesters must hold char stable while valid & !ready.
- A re-grant always re-emits the prefix, including when the same single port wins again.
- Reset mid-stream returns the FSM to IDLE in the next cycle. A partially sent prefix is abandoned, and no char is accepted in the reset cycle.

## Timing

- Grant latency: a request in IDLE leads to the first out_valid (prefix or data) one cycle later.
- STREAM path is combinational: req_valid/req_char go to out_valid/out_char, and out_ready goes to req_ready, with zero latency.
- Prefix overhead is 2 transfers per grant, each stallable by out_ready.
- After an LF or a timeout there is one IDLE bubble cycle before the next owner.
- Throughput in STREAM is one char per cycle.

## Structure

- Shared package osd_dem_uart_pkg holds:
  - constants ASCII_LF=8'h0A, ASCII_ZERO=8'h30, ASCII_COLON=8'h3A;
  - the typedef enum for the FSM states.
- Sub-module osd_rr_arbiter, parameterized by N:
  - inputs are the request vector and last index;
  - outputs are a one-hot grant plus the encoded index;
  - it is purely combinational and reusable for the receive-side router.

## Test plan

- Single port, reset, then port 2 sends "A\n" with out_ready=1. Expect out_char sequence 8'h32, 8'h3A, 8'h41, 8'h0A, then IDLE; req_ready[2] is high only on the last two chars.
- Ports 0 and 1 both request continuously, each sending "x\n". Grants alternate 0,1,0,1, and the prefixes alternate between 8'h30 and 8'h31.
- out_ready held low for 5 cycles during PREFIX_ID. out_char stays 8'h30 and out_valid stays 1; no req_ready is asserted.
- TIMEOUT=4: port 1 sends "ab" without LF, then its valid drops. Release to IDLE follows 4 idle cycles; a pending port 3 is granted next with prefix 8'h33.
- Port 0 sends LF in the same cycle the counter reaches TIMEOUT. Exactly one release occurs, LF is accepted, and the next grant has a fresh prefix.
- rst asserted while in PREFIX_SEP. The next cycle has out_valid=0, owner_valid=0 and owner=0, and port 0 wins the following arbitration.
